// File: rtl/br_redirect_ctrl.sv
// Branch resolution back-end: mispredict detection, flush/redirect FSM and predictor update queue.
// Optional statistics counters are built when BR_STAT_EN is defined.
module br_redirect_ctrl #(
  parameter int UPD_DEPTH = 4,
  parameter int TAG_WD    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_taken,
  input  logic [31:0]       in_target,
  input  logic [31:0]       in_pc,
  input  logic              in_pred_taken,
  input  logic [31:0]       in_pred_target,
  input  logic [TAG_WD-1:0] in_tag,
  output logic              bru_ready,
  output logic              flush,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic [TAG_WD-1:0] redirect_tag,
  input  logic              redirect_ready,
  output logic              upd_valid,
  output logic [31:0]       upd_pc,
  output logic [31:0]       upd_target,
  output logic              upd_taken,
  input  logic              upd_ready
`ifdef BR_STAT_EN
  ,
  output logic [31:0]       stat_br_cnt,
  output logic [31:0]       stat_mp_cnt
`endif
);

  localparam int PTR_W = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FLUSH, WAIT_ACK} state_e;

  state_e              state_q;
  logic                flush_q;
  logic                redirect_valid_q;
  logic [31:0]         redirect_pc_q;
  logic [TAG_WD-1:0]   redirect_tag_q;

  logic [31:0]         q_pc_q  [UPD_DEPTH];
  logic [31:0]         q_tgt_q [UPD_DEPTH];
  logic [UPD_DEPTH-1:0] q_tkn_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                q_full;
  logic                accept;
  logic                pop;
  logic                mispredict;
  logic [31:0]         correct_pc;

  assign q_full     = (cnt_q == CNT_W'(UPD_DEPTH));
  assign bru_ready  = (state_q == IDLE) & ~q_full;
  assign accept     = in_valid & bru_ready;
  assign upd_valid  = (cnt_q != '0);
  assign pop        = upd_valid & upd_ready;

  assign mispredict = (in_taken != in_pred_taken) |
                      (in_taken & (in_target != in_pred_target));
  // Not-taken branches resume after the delay slot.
  assign correct_pc = in_taken ? in_target : (in_pc + 32'd8);

  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign redirect_tag   = redirect_tag_q;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      redirect_tag_q   <= '0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && mispredict) begin
            state_q          <= FLUSH;
            flush_q          <= 1'b1;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= correct_pc;
            redirect_tag_q   <= in_tag;
          end
        end
        FLUSH: begin
          if (redirect_ready) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
          end else begin
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (redirect_ready) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q          <= IDLE;
          redirect_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!accept && pop) cnt_d = cnt_q - CNT_W'(1);
  end

  // NOTE: the queue storage is reset because the head entry drives the upd_*
  // outputs directly and those must read zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < UPD_DEPTH; i++) begin
        q_pc_q[i]  <= '0;
        q_tgt_q[i] <= '0;
      end
      q_tkn_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        q_pc_q[wr_ptr_q]  <= in_pc;
        q_tgt_q[wr_ptr_q] <= in_target;
        q_tkn_q[wr_ptr_q] <= in_taken;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  assign upd_pc     = q_pc_q[rd_ptr_q];
  assign upd_target = q_tgt_q[rd_ptr_q];
  assign upd_taken  = q_tkn_q[rd_ptr_q];

`ifdef BR_STAT_EN
  logic [31:0] br_cnt_q, mp_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else if (accept) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (mispredict) mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  assign stat_br_cnt = br_cnt_q;
  assign stat_mp_cnt = mp_cnt_q;
`endif

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Self-checking bench for br_redirect_ctrl: scoreboard on the update queue plus
// cycle-exact checks of flush/redirect/back-pressure behaviour.
module tb_br_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_taken, in_pred_taken;
  logic [31:0] in_target, in_pc, in_pred_target;
  logic [5:0]  in_tag;
  logic        bru_ready, flush, redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;
  logic [5:0]  redirect_tag;
  logic        upd_valid, upd_taken, upd_ready;
  logic [31:0] upd_pc, upd_target;
`ifdef BR_STAT_EN
  logic [31:0] stat_br_cnt, stat_mp_cnt;
`endif

  br_redirect_ctrl #(.UPD_DEPTH(4), .TAG_WD(6)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_taken(in_taken), .in_target(in_target), .in_pc(in_pc),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target), .in_tag(in_tag),
    .bru_ready(bru_ready), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_tag(redirect_tag),
    .redirect_ready(redirect_ready),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_ready(upd_ready)
`ifdef BR_STAT_EN
    , .stat_br_cnt(stat_br_cnt), .stat_mp_cnt(stat_mp_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } upd_t;

  upd_t exp_q[$];
  int   passed = 0;
  int   total  = 0;
  int   br_m   = 0;
  int   mp_m   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt, input logic [5:0] tag);
    in_pc = pc; in_taken = tk; in_target = tgt;
    in_pred_taken = ptk; in_pred_target = ptgt; in_tag = tag;
  endtask

  // Record an accepted branch in the scoreboard and the statistics model.
  task automatic push_exp();
    upd_t e;
    e.pc = in_pc; e.taken = in_taken; e.target = in_target;
    exp_q.push_back(e);
    br_m++;
    if ((in_taken != in_pred_taken) || (in_taken && (in_target != in_pred_target))) mp_m++;
  endtask

  // Present one branch and hold it until accepted; returns one cycle after acceptance.
  task automatic drive_br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt, input logic [5:0] tag);
    bit done = 0;
    set_br(pc, tk, tgt, ptk, ptgt, tag);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bru_ready === 1'b1) begin
        push_exp();
        done = 1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) begin
      total++;
      $display("FAIL accept_timeout: pc %h not accepted within 20 cycles", pc);
    end
  endtask

  // Pop n entries through upd_ready and compare each head against the scoreboard.
  task automatic drain(input int n);
    int got = 0;
    upd_t e;
    upd_ready = 1'b1;
    for (int i = 0; i < 40 && got < n; i++) begin
      if (upd_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL upd_unexpected: got pc %h with empty scoreboard", upd_pc);
        end else begin
          e = exp_q.pop_front();
          if ({upd_pc, upd_taken, upd_target} !== {e.pc, e.taken, e.target})
            $display("FAIL upd_entry: got {%h,%b,%h} want {%h,%b,%h}",
                     upd_pc, upd_taken, upd_target, e.pc, e.taken, e.target);
          else passed++;
        end
        got++;
      end
      tick();
    end
    upd_ready = 1'b0;
    total++;
    if (got != n) $display("FAIL drain_count: got %0d entries want %0d", got, n);
    else passed++;
    total++;
    if (upd_valid !== 1'b0) $display("FAIL drain_empty: upd_valid %b want 0", upd_valid);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; redirect_ready = 1'b1; upd_ready = 1'b0;
    set_br('0, 1'b0, '0, 1'b0, '0, '0);
    tick(); tick();
    rst = 1'b0;
    tick();
    total++; if (flush !== 1'b0) $display("FAIL reset_flush: got %b want 0", flush); else passed++;
    total++; if (redirect_valid !== 1'b0) $display("FAIL reset_rv: got %b want 0", redirect_valid); else passed++;
    total++; if (redirect_pc !== 32'h0) $display("FAIL reset_rpc: got %h want 0", redirect_pc); else passed++;
    total++; if (redirect_tag !== 6'h0) $display("FAIL reset_rtag: got %h want 0", redirect_tag); else passed++;
    total++; if (upd_valid !== 1'b0) $display("FAIL reset_upd_valid: got %b want 0", upd_valid); else passed++;
    total++; if ({upd_pc, upd_taken, upd_target} !== 65'h0)
      $display("FAIL reset_upd_data: got {%h,%b,%h} want 0", upd_pc, upd_taken, upd_target); else passed++;
    total++; if (bru_ready !== 1'b1) $display("FAIL reset_bru_ready: got %b want 1", bru_ready); else passed++;
`ifdef BR_STAT_EN
    total++; if ({stat_br_cnt, stat_mp_cnt} !== 64'h0)
      $display("FAIL reset_stats: got %h/%h want 0/0", stat_br_cnt, stat_mp_cnt); else passed++;
`endif
  endtask

  task automatic test_correct();
    drive_br(32'h1000, 1'b1, 32'h2000, 1'b1, 32'h2000, 6'd1);
    total++; if (flush !== 1'b0) $display("FAIL correct_flush: got %b want 0", flush); else passed++;
    total++; if (redirect_valid !== 1'b0) $display("FAIL correct_rv: got %b want 0", redirect_valid); else passed++;
    total++; if (bru_ready !== 1'b1) $display("FAIL correct_bru_ready: got %b want 1", bru_ready); else passed++;
    total++; if (upd_valid !== 1'b1) $display("FAIL correct_upd_valid: got %b want 1", upd_valid); else passed++;
    drain(1);
  endtask

  task automatic test_not_taken_mp();
    redirect_ready = 1'b1;
    drive_br(32'h1000, 1'b0, 32'h1234, 1'b1, 32'h5000, 6'd5);
    total++; if (flush !== 1'b1) $display("FAIL nt_flush: got %b want 1", flush); else passed++;
    total++; if (redirect_valid !== 1'b1) $display("FAIL nt_rv: got %b want 1", redirect_valid); else passed++;
    total++; if (redirect_pc !== 32'h1008) $display("FAIL nt_rpc: got %h want 00001008", redirect_pc); else passed++;
    total++; if (redirect_tag !== 6'd5) $display("FAIL nt_rtag: got %0d want 5", redirect_tag); else passed++;
    total++; if (bru_ready !== 1'b0) $display("FAIL nt_bru_busy: got %b want 0", bru_ready); else passed++;
    tick();
    total++; if (flush !== 1'b0) $display("FAIL nt_flush_end: got %b want 0", flush); else passed++;
    total++; if (redirect_valid !== 1'b0) $display("FAIL nt_rv_end: got %b want 0", redirect_valid); else passed++;
    total++; if (bru_ready !== 1'b1) $display("FAIL nt_bru_idle: got %b want 1", bru_ready); else passed++;
    drain(1);
  endtask

  task automatic test_wrong_target();
    redirect_ready = 1'b0;
    drive_br(32'h1100, 1'b1, 32'h3000, 1'b1, 32'h2000, 6'd9);
    // A younger branch waits on the bus; it must not be captured while stalled.
    set_br(32'h1200, 1'b0, 32'h0, 1'b0, 32'h0, 6'd10);
    in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      total++; if (flush !== (k == 1)) $display("FAIL wt_flush_c%0d: got %b want %b", k, flush, k == 1); else passed++;
      total++; if (redirect_valid !== 1'b1) $display("FAIL wt_rv_c%0d: got %b want 1", k, redirect_valid); else passed++;
      total++; if (redirect_pc !== 32'h3000) $display("FAIL wt_rpc_c%0d: got %h want 00003000", k, redirect_pc); else passed++;
      total++; if (bru_ready !== 1'b0) $display("FAIL wt_bru_c%0d: got %b want 0", k, bru_ready); else passed++;
      if (k == 4) redirect_ready = 1'b1;
      tick();
    end
    total++; if (redirect_valid !== 1'b0) $display("FAIL wt_rv_end: got %b want 0", redirect_valid); else passed++;
    total++; if (bru_ready !== 1'b1) $display("FAIL wt_bru_end: got %b want 1", bru_ready); else passed++;
    push_exp();
    tick();
    in_valid = 1'b0;
    drain(2);
  endtask

  task automatic test_back_to_back();
    redirect_ready = 1'b1;
    drive_br(32'h2000, 1'b1, 32'h2400, 1'b0, 32'h0, 6'd11);
    total++; if (flush !== 1'b1) $display("FAIL b2b_flush1: got %b want 1", flush); else passed++;
    set_br(32'h2400, 1'b1, 32'h2800, 1'b1, 32'h2C00, 6'd12);
    in_valid = 1'b1;
    tick();
    total++; if (flush !== 1'b0) $display("FAIL b2b_gap: got %b want 0", flush); else passed++;
    total++; if (bru_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", bru_ready); else passed++;
    push_exp();
    tick();
    in_valid = 1'b0;
    total++; if (flush !== 1'b1) $display("FAIL b2b_flush2: got %b want 1", flush); else passed++;
    total++; if (redirect_pc !== 32'h2800) $display("FAIL b2b_rpc: got %h want 00002800", redirect_pc); else passed++;
    total++; if (redirect_tag !== 6'd12) $display("FAIL b2b_rtag: got %0d want 12", redirect_tag); else passed++;
    tick();
    drain(2);
  endtask

  task automatic test_queue_full();
    upd_t e;
    redirect_ready = 1'b1;
    upd_ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      drive_br(32'h100 * i, 1'b1, 32'h8000 + 32'h10 * i, 1'b1, 32'h8000 + 32'h10 * i, 6'(i));
    total++; if (bru_ready !== 1'b0) $display("FAIL full_bru: got %b want 0", bru_ready); else passed++;
    set_br(32'h500, 1'b1, 32'h8050, 1'b1, 32'h8050, 6'd5);
    in_valid = 1'b1;
    tick();
    total++; if (bru_ready !== 1'b0) $display("FAIL full_hold: got %b want 0", bru_ready); else passed++;
    // Pop one entry while still full: acceptance stays blocked for this cycle.
    e = exp_q.pop_front();
    total++; if ({upd_pc, upd_taken, upd_target} !== {e.pc, e.taken, e.target})
      $display("FAIL full_head: got {%h,%b,%h} want {%h,%b,%h}",
               upd_pc, upd_taken, upd_target, e.pc, e.taken, e.target); else passed++;
    upd_ready = 1'b1;
    total++; if (bru_ready !== 1'b0) $display("FAIL full_pop_same: got %b want 0", bru_ready); else passed++;
    tick();
    upd_ready = 1'b0;
    total++; if (bru_ready !== 1'b1) $display("FAIL full_after_pop: got %b want 1", bru_ready); else passed++;
    push_exp();
    tick();
    in_valid = 1'b0;
    total++; if (bru_ready !== 1'b0) $display("FAIL full_again: got %b want 0", bru_ready); else passed++;
    drain(4);
  endtask

  task automatic test_pc_wrap();
    redirect_ready = 1'b1;
    drive_br(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h1000, 6'd33);
    total++; if (redirect_pc !== 32'h0000_0004) $display("FAIL wrap_rpc: got %h want 00000004", redirect_pc); else passed++;
    total++; if (flush !== 1'b1) $display("FAIL wrap_flush: got %b want 1", flush); else passed++;
    tick();
    drain(1);
  endtask

  task automatic test_reset_mid();
    redirect_ready = 1'b0;
    upd_ready = 1'b0;
    drive_br(32'h3000, 1'b0, 32'h0, 1'b0, 32'h0, 6'd20);
    drive_br(32'h4000, 1'b1, 32'h4400, 1'b0, 32'h0, 6'd3);
    tick();
    total++; if (redirect_valid !== 1'b1) $display("FAIL rmid_rv_pre: got %b want 1", redirect_valid); else passed++;
`ifdef BR_STAT_EN
    total++; if (stat_br_cnt !== 32'(br_m)) $display("FAIL stat_br: got %0d want %0d", stat_br_cnt, br_m); else passed++;
    total++; if (stat_mp_cnt !== 32'(mp_m)) $display("FAIL stat_mp: got %0d want %0d", stat_mp_cnt, mp_m); else passed++;
`endif
    rst = 1'b1;
    tick();
    exp_q.delete();
    br_m = 0; mp_m = 0;
    total++; if (redirect_valid !== 1'b0) $display("FAIL rmid_rv: got %b want 0", redirect_valid); else passed++;
    total++; if (upd_valid !== 1'b0) $display("FAIL rmid_upd_valid: got %b want 0", upd_valid); else passed++;
    total++; if (bru_ready !== 1'b1) $display("FAIL rmid_bru: got %b want 1", bru_ready); else passed++;
    total++; if (flush !== 1'b0) $display("FAIL rmid_flush: got %b want 0", flush); else passed++;
`ifdef BR_STAT_EN
    total++; if ({stat_br_cnt, stat_mp_cnt} !== 64'h0)
      $display("FAIL rmid_stats: got %h/%h want 0/0", stat_br_cnt, stat_mp_cnt); else passed++;
`endif
    rst = 1'b0;
    redirect_ready = 1'b1;
    tick();
    total++; if (flush !== 1'b0) $display("FAIL rmid_no_flush: got %b want 0", flush); else passed++;
    total++; if (redirect_valid !== 1'b0) $display("FAIL rmid_rv_post: got %b want 0", redirect_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_correct();
    test_not_taken_mp();
    test_wrong_target();
    test_back_to_back();
    test_queue_full();
    test_pc_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
